dcache_st_port: RTL and testbench
=================================

DCACHE_ST_PORT -- requirements
Module: dcache_st_port

Interface
REQ-001 Parameter IDX_BITS, default 7, number of D$ index bits (direct-mapped, 2^IDX_BITS lines).
REQ-002 Parameter OFF_BITS, default 5, line-offset bits; word index = va[OFF_BITS-1:3]; tag = va[msb of `VA_BITS : IDX_BITS+OFF_BITS].
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 rtr_st_vld_xx  input  1  store request valid from store buffer.
REQ-006 rtr_st_be_xx  input  8  byte enables, lane-aligned.
REQ-007 rtr_st_data_xx  input  64  lane-aligned store data.
REQ-008 rtr_st_addr_xx  input  `VA_BITS  store virtual address.
REQ-009 rtr_st_ack_xx  output  1  one-cycle pulse: request retired into D$.
REQ-010 ld_busy_e0  input  1  load pipe owns tag/data arrays this cycle.
REQ-011 tag_rd_en / tag_rd_idx  output  1 / IDX_BITS  tag array read, data valid next cycle.
REQ-012 tag_rd_tag / tag_rd_vld  input  tag width / 1  tag and valid bit returned one cycle after tag_rd_en.
REQ-013 dat_wr_en / dat_wr_idx / dat_wr_be / dat_wr_data  output  1 / IDX_BITS+OFF_BITS-3 / 8 / 64  data array byte-masked write.
REQ-014 miss_req / miss_addr  output  1 / `VA_BITS  line fill request, addr line-aligned (offset bits zero).
REQ-015 miss_done  input  1  one-cycle pulse: fill for miss_addr complete.

Function
REQ-016 FSM states SHALL be IDLE, LOOKUP, WRITE, MISS.
REQ-017 IDLE: vld & ~ld_busy_e0 -> tag_rd_en=1, tag_rd_idx from addr, latch addr/be/data, go LOOKUP; else stay, no outputs.
REQ-018 LOOKUP: hit = tag_rd_vld & (tag_rd_tag == latched tag); miss = ~hit.
REQ-019 LOOKUP hit & ~ld_busy_e0 -> dat_wr_en=1 with latched be/data, rtr_st_ack_xx=1 same cycle, go IDLE.
REQ-020 LOOKUP hit & ld_busy_e0 -> go WRITE; WRITE holds until ~ld_busy_e0, then writes and acks as REQ-019.
REQ-021 LOOKUP miss -> go MISS; miss_req held high with latched line address until miss_done, then go IDLE (relookup; no write, no ack).
REQ-022 Uncontended hit latency: vld sampled cycle N, write+ack cycle N+1; back-to-back stores retire every 2 cycles.
REQ-023 Exactly one ack per accepted request; never ack in IDLE or MISS.
REQ-024 After accept, latched request completes regardless of input changes; vld deasserting early still produces its ack.
REQ-025 miss_done outside MISS ignored; ld_busy_e0 only affects IDLE accept and write cycles.
REQ-026 vld high in the cycle after ack is treated as a new request.

Reset
REQ-027 reset_n low asynchronously forces IDLE; ack, tag_rd_en, dat_wr_en, miss_req low; latched payload cleared to 0.
REQ-028 Reset mid-LOOKUP/WRITE/MISS abandons the transaction without ack; a pending fill is dropped.

Configuration
REQ-029 Macro DCST_PERF_EN: defined -> outputs perf_hit_cnt and perf_miss_cnt (32 bits each) increment once per LOOKUP hit/miss, wrap at 2^32, reset to 0; undefined -> ports and counters absent, behaviour otherwise identical.

Structure
REQ-030 FSM state enum and tag/index/offset width localparams derived from `VA_BITS SHALL live in the shared D$ package.
REQ-031 Single module; no sub-module needed (optional dcst_tag_cmp comparator allowed).

Verification
REQ-032 Hit: tag array holds tag of 0x1008, store be=0x0F data=0x11223344 -> dat_wr_be=0x0F, dat_wr_idx=1, ack at N+1.
REQ-033 Load contention: ld_busy_e0 high cycles N..N+2 with vld at N -> accept at N+3, ack at N+4.
REQ-034 Miss: tag_rd_vld=0 -> miss_req with miss_addr=0x1000, miss_done 10 cycles later -> relookup, hit, single ack.
REQ-035 Back-to-back: 4 hitting stores, vld held high -> 4 acks on alternate cycles, writes in order.
REQ-036 Reset_n pulsed during MISS -> miss_req drops immediately, no ack, next request processed normally.
REQ-037 DCST_PERF_EN build: 3 hits + 1 miss (plus relookup hit) -> perf_hit_cnt=4, perf_miss_cnt=1.

Source files
------------

// File: rtl/dcache_st_port_pkg.sv
// Shared D$ store-port definitions: FSM state type, default geometry and VA width.
// VA_BITS defaults to 39 when the build does not supply it.
`ifndef VA_BITS
`define VA_BITS 39
`endif

package dcache_st_port_pkg;

  localparam int unsigned VaBits     = `VA_BITS;
  localparam int unsigned DefIdxBits = 7;
  localparam int unsigned DefOffBits = 5;

  typedef enum logic [1:0] {
    StIdle,
    StLookup,
    StWrite,
    StMiss
  } st_state_e;

  function automatic int unsigned tag_bits(int unsigned idx_bits, int unsigned off_bits);
    return VaBits - idx_bits - off_bits;
  endfunction

endpackage

// File: rtl/dcache_st_port_tag_cmp.sv
// Tag compare for the store port: hit when the returned line is valid and its tag matches.

module dcache_st_port_tag_cmp #(
  parameter int unsigned TagBits = 27
) (
  input  logic [TagBits-1:0] rd_tag,
  input  logic               rd_vld,
  input  logic [TagBits-1:0] req_tag,
  output logic               hit
);

  assign hit = rd_vld & (rd_tag == req_tag);

endmodule

// File: rtl/dcache_st_port.sv
// Store-buffer to D$ write port: tag lookup, byte-masked data write, line fill on miss.
// Optional DCST_PERF_EN adds 32-bit hit/miss lookup counters.

module dcache_st_port
  import dcache_st_port_pkg::*;
#(
  parameter int unsigned IDX_BITS = DefIdxBits,
  parameter int unsigned OFF_BITS = DefOffBits
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                rtr_st_vld_xx,
  input  logic [7:0]                          rtr_st_be_xx,
  input  logic [63:0]                         rtr_st_data_xx,
  input  logic [VaBits-1:0]                   rtr_st_addr_xx,
  output logic                                rtr_st_ack_xx,
  input  logic                                ld_busy_e0,
  output logic                                tag_rd_en,
  output logic [IDX_BITS-1:0]                 tag_rd_idx,
  input  logic [VaBits-IDX_BITS-OFF_BITS-1:0] tag_rd_tag,
  input  logic                                tag_rd_vld,
  output logic                                dat_wr_en,
  output logic [IDX_BITS+OFF_BITS-4:0]        dat_wr_idx,
  output logic [7:0]                          dat_wr_be,
  output logic [63:0]                         dat_wr_data,
  output logic                                miss_req,
  output logic [VaBits-1:0]                   miss_addr,
  input  logic                                miss_done
`ifdef DCST_PERF_EN
  ,
  output logic [31:0]                         perf_hit_cnt,
  output logic [31:0]                         perf_miss_cnt
`endif
);

  localparam int unsigned LineBits = IDX_BITS + OFF_BITS;
  localparam int unsigned TagBits  = tag_bits(IDX_BITS, OFF_BITS);

  st_state_e         state_q, state_d;
  logic [VaBits-1:3] addr_q;
  logic [7:0]        be_q;
  logic [63:0]       data_q;
  logic              accept;
  logic              hit;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^rtr_st_addr_xx[2:0];

  // Gate with reset so no array read escapes while reset is held.
  assign accept = reset_n & rtr_st_vld_xx & ~ld_busy_e0;

  dcache_st_port_tag_cmp #(
    .TagBits(TagBits)
  ) u_tag_cmp (
    .rd_tag (tag_rd_tag),
    .rd_vld (tag_rd_vld),
    .req_tag(addr_q[VaBits-1:LineBits]),
    .hit    (hit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      be_q   <= '0;
      data_q <= '0;
    end else if (state_q == StIdle && accept) begin
      addr_q <= rtr_st_addr_xx[VaBits-1:3];
      be_q   <= rtr_st_be_xx;
      data_q <= rtr_st_data_xx;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StLookup;
      StLookup: begin
        if (!hit)           state_d = StMiss;
        else if (ld_busy_e0) state_d = StWrite;
        else                 state_d = StIdle;
      end
      StWrite:  if (!ld_busy_e0) state_d = StIdle;
      // Return to IDLE so the still-pending store is looked up again.
      StMiss:   if (miss_done) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    tag_rd_en = 1'b0;
    dat_wr_en = 1'b0;
    miss_req  = 1'b0;
    unique case (state_q)
      StIdle:   tag_rd_en = accept;
      StLookup: dat_wr_en = hit & ~ld_busy_e0;
      StWrite:  dat_wr_en = ~ld_busy_e0;
      StMiss:   miss_req  = 1'b1;
      default:  ;
    endcase
    rtr_st_ack_xx = dat_wr_en;
  end

  assign tag_rd_idx  = rtr_st_addr_xx[LineBits-1:OFF_BITS];
  assign dat_wr_idx  = addr_q[LineBits-1:3];
  assign dat_wr_be   = be_q;
  assign dat_wr_data = data_q;
  assign miss_addr   = {addr_q[VaBits-1:OFF_BITS], {OFF_BITS{1'b0}}};

`ifdef DCST_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else if (state_q == StLookup) begin
      if (hit) perf_hit_cnt  <= perf_hit_cnt + 32'd1;
      else     perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_st_port.sv
// Scoreboard bench for dcache_st_port: tag/fill model, directed scenarios, random stores.

module tb_dcache_st_port;
  import dcache_st_port_pkg::*;

  localparam int unsigned IdxBits  = 7;
  localparam int unsigned OffBits  = 5;
  localparam int unsigned LineBits = IdxBits + OffBits;
  localparam int unsigned TagBits  = VaBits - LineBits;
  localparam int unsigned Lines    = 1 << IdxBits;

  typedef struct packed {
    logic [LineBits-4:0] idx;
    logic [7:0]          be;
    logic [63:0]         data;
  } wr_exp_t;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                rtr_st_vld_xx, rtr_st_ack_xx, ld_busy_e0;
  logic [7:0]          rtr_st_be_xx;
  logic [63:0]         rtr_st_data_xx;
  logic [VaBits-1:0]   rtr_st_addr_xx;
  logic                tag_rd_en, tag_rd_vld;
  logic [IdxBits-1:0]  tag_rd_idx;
  logic [TagBits-1:0]  tag_rd_tag;
  logic                dat_wr_en;
  logic [LineBits-4:0] dat_wr_idx;
  logic [7:0]          dat_wr_be;
  logic [63:0]         dat_wr_data;
  logic                miss_req, miss_done;
  logic [VaBits-1:0]   miss_addr;
`ifdef DCST_PERF_EN
  logic [31:0]         perf_hit_cnt, perf_miss_cnt;
`endif

  // Reference state: tag array contents plus queues of expected writes and fills.
  logic [TagBits-1:0]  tag_mem  [Lines];
  bit                  line_vld [Lines];
  wr_exp_t             exp_wr_q[$];
  logic [VaBits-1:0]   exp_miss_q[$];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          busy_hold = 0;
  int          fill_cnt = 0;
  bit          fill_active = 0;
  bit          rand_busy = 0;
  logic [VaBits-1:0] fill_line;
  int unsigned model_hits = 0;
  int unsigned model_misses = 0;

  always #5 clk = ~clk;

  dcache_st_port dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rtr_st_vld_xx (rtr_st_vld_xx),
    .rtr_st_be_xx  (rtr_st_be_xx),
    .rtr_st_data_xx(rtr_st_data_xx),
    .rtr_st_addr_xx(rtr_st_addr_xx),
    .rtr_st_ack_xx (rtr_st_ack_xx),
    .ld_busy_e0    (ld_busy_e0),
    .tag_rd_en     (tag_rd_en),
    .tag_rd_idx    (tag_rd_idx),
    .tag_rd_tag    (tag_rd_tag),
    .tag_rd_vld    (tag_rd_vld),
    .dat_wr_en     (dat_wr_en),
    .dat_wr_idx    (dat_wr_idx),
    .dat_wr_be     (dat_wr_be),
    .dat_wr_data   (dat_wr_data),
    .miss_req      (miss_req),
    .miss_addr     (miss_addr),
    .miss_done     (miss_done)
`ifdef DCST_PERF_EN
    ,
    .perf_hit_cnt  (perf_hit_cnt),
    .perf_miss_cnt (perf_miss_cnt)
`endif
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample DUT at negedge, then drive tag data, fill response and ld_busy after posedge.
  task automatic tick(output bit ack_s, output bit miss_s);
    bit                 rd_en;
    logic [IdxBits-1:0] rd_idx;
    @(negedge clk);
    ack_s  = rtr_st_ack_xx;
    miss_s = miss_req;
    rd_en  = tag_rd_en;
    rd_idx = tag_rd_idx;
    if (!reset_n || !miss_s) begin
      fill_active = 0;
    end else if (!fill_active) begin
      fill_active = 1;
      fill_cnt    = 10;
      fill_line   = miss_addr;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (rd_en) begin
      tag_rd_tag = tag_mem[rd_idx];
      tag_rd_vld = line_vld[rd_idx];
    end
    miss_done = 1'b0;
    if (!reset_n) begin
      fill_cnt = 0;
    end else if (fill_cnt > 0) begin
      fill_cnt--;
      if (fill_cnt == 0) begin
        tag_mem[fill_line[LineBits-1:OffBits]]  = fill_line[VaBits-1:LineBits];
        line_vld[fill_line[LineBits-1:OffBits]] = 1;
        miss_done = 1'b1;
      end
    end
    if (busy_hold > 0) begin
      ld_busy_e0 = 1'b1;
      busy_hold--;
    end else begin
      ld_busy_e0 = rand_busy ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  endtask

  // Present one store, hold it until acked (store-buffer behaviour), record expectations.
  task automatic do_store(input logic [VaBits-1:0] addr, input logic [7:0] be,
                          input logic [63:0] data, input int exp_lat);
    logic [IdxBits-1:0] idx;
    logic [TagBits-1:0] tag;
    wr_exp_t            e;
    bit                 ack_s, miss_s, got;
    int                 issue, lat;
    idx = addr[LineBits-1:OffBits];
    tag = addr[VaBits-1:LineBits];
    if (!(line_vld[idx] && tag_mem[idx] == tag)) begin
      exp_miss_q.push_back({addr[VaBits-1:OffBits], {OffBits{1'b0}}});
      model_misses++;
    end
    model_hits++;
    e.idx  = addr[LineBits-1:3];
    e.be   = be;
    e.data = data;
    exp_wr_q.push_back(e);
    rtr_st_addr_xx = addr;
    rtr_st_be_xx   = be;
    rtr_st_data_xx = data;
    rtr_st_vld_xx  = 1'b1;
    issue = cyc;
    got   = 0;
    lat   = 0;
    for (int k = 0; k < 400; k++) begin
      tick(ack_s, miss_s);
      if (ack_s) begin
        got = 1;
        lat = cyc - 1 - issue;
        break;
      end
    end
    rtr_st_vld_xx = 1'b0;
    check("ack_seen", 128'(got), 128'(1));
    if (got && exp_lat >= 0) check("ack_latency", 128'(lat), 128'(exp_lat));
  endtask

  // Monitor: every data write is popped against the scoreboard; fills checked on miss_req rise.
  initial begin
    bit      prev_miss;
    wr_exp_t e;
    prev_miss = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_miss = 0;
      end else begin
        if (dat_wr_en) begin
          if (exp_wr_q.size() == 0) begin
            check("unexpected_write", 128'({dat_wr_idx, dat_wr_be, dat_wr_data}), 128'(0));
          end else begin
            e = exp_wr_q.pop_front();
            check("write_idx_be_data", 128'({dat_wr_idx, dat_wr_be, dat_wr_data}), 128'(e));
          end
          check("ack_with_write", 128'(rtr_st_ack_xx), 128'(1));
        end else if (rtr_st_ack_xx) begin
          check("ack_without_write", 128'(rtr_st_ack_xx), 128'(0));
        end
        if (miss_req && !prev_miss) begin
          if (exp_miss_q.size() == 0) check("unexpected_miss", 128'(miss_addr), 128'(0));
          else check("miss_addr", 128'(miss_addr), 128'(exp_miss_q.pop_front()));
        end
        prev_miss = miss_req;
      end
    end
  end

  initial begin
    bit ack_s, miss_s, seen;
    reset_n        = 1'b0;
    rtr_st_vld_xx  = 1'b1;
    rtr_st_be_xx   = 8'hff;
    rtr_st_data_xx = '1;
    rtr_st_addr_xx = VaBits'(32'h1008);
    ld_busy_e0     = 1'b0;
    miss_done      = 1'b0;
    tag_rd_tag     = '0;
    tag_rd_vld     = 1'b0;
    for (int i = 0; i < Lines; i++) begin
      tag_mem[i]  = '0;
      line_vld[i] = 0;
    end
    tick(ack_s, miss_s);
    tick(ack_s, miss_s);
    // Reset held with a valid request present: nothing may start.
    check("rst_tag_rd_en", 128'(tag_rd_en), 128'(0));
    check("rst_ack", 128'(rtr_st_ack_xx), 128'(0));
    check("rst_dat_wr_en", 128'(dat_wr_en), 128'(0));
    check("rst_miss_req", 128'(miss_req), 128'(0));
    check("rst_payload", 128'({dat_wr_be, dat_wr_data, dat_wr_idx}), 128'(0));
    check("rst_miss_addr", 128'(miss_addr), 128'(0));
    rtr_st_vld_xx = 1'b0;
    reset_n = 1'b1;
    tick(ack_s, miss_s);

    // Hit at 0x1008: index 0, tag 1, word 1.
    tag_mem[0]  = TagBits'(1);
    line_vld[0] = 1;
    do_store(VaBits'(32'h1008), 8'h0f, 64'h1122_3344, 1);

    // Load contention for three cycles starting with the request cycle.
    ld_busy_e0 = 1'b1;
    busy_hold  = 2;
    do_store(VaBits'(32'h1010), 8'hf0, 64'hdead_beef_0000_0000, 4);

    // Back-to-back hits with vld kept high: one ack every other cycle.
    tag_mem[1]  = TagBits'(1);
    line_vld[1] = 1;
    do_store(VaBits'(32'h1000), 8'h01, 64'h0000_0000_0000_00a1, 1);
    do_store(VaBits'(32'h1028), 8'h80, 64'hb200_0000_0000_0000, 1);
    do_store(VaBits'(32'h1018), 8'h3c, 64'h0000_c3c3_c3c3_0000, 1);
    do_store(VaBits'(32'h1030), 8'hff, 64'h0123_4567_89ab_cdef, 1);

    // Miss: fill 10 cycles after miss_req, then relookup, hit and a single ack.
    line_vld[0] = 0;
    do_store(VaBits'(32'h1010), 8'h0c, 64'h0000_0000_5566_0000, 14);

    // Reset while waiting for a fill.
    line_vld[2] = 0;
    exp_miss_q.push_back(VaBits'(32'h1040));
    rtr_st_addr_xx = VaBits'(32'h1048);
    rtr_st_be_xx   = 8'h11;
    rtr_st_data_xx = 64'h7777;
    rtr_st_vld_xx  = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick(ack_s, miss_s);
      if (miss_s) begin
        seen = 1;
        break;
      end
    end
    check("miss_before_reset", 128'(seen), 128'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_miss_req", 128'(miss_req), 128'(0));
    check("rst_mid_ack", 128'(rtr_st_ack_xx), 128'(0));
    check("rst_mid_miss_addr", 128'(miss_addr), 128'(0));
    rtr_st_vld_xx = 1'b0;
    exp_wr_q.delete();
    exp_miss_q.delete();
    model_hits   = 0;
    model_misses = 0;
    tick(ack_s, miss_s);
    tick(ack_s, miss_s);
    reset_n = 1'b1;
    tick(ack_s, miss_s);
    check("fill_dropped", 128'(line_vld[2]), 128'(0));

    // Three hits and one miss after reset (the miss relooks up as a hit).
    do_store(VaBits'(32'h1008), 8'h0f, 64'h1122_3344, 1);
    do_store(VaBits'(32'h1028), 8'h02, 64'h0000_0000_0000_9900, 1);
    do_store(VaBits'(32'h1000), 8'hc0, 64'hab12_0000_0000_0000, 1);
    do_store(VaBits'(32'h2000), 8'h81, 64'h5a00_0000_0000_00a5, 14);
`ifdef DCST_PERF_EN
    check("perf_hit_cnt", 128'(perf_hit_cnt), 128'(4));
    check("perf_miss_cnt", 128'(perf_miss_cnt), 128'(1));
`endif

    // Random stores over a few lines and tags, with random load contention.
    for (int i = 0; i < 8; i++) begin
      line_vld[i] = bit'($urandom_range(0, 1));
      tag_mem[i]  = TagBits'($urandom_range(0, 3));
    end
    rand_busy = 1;
    for (int n = 0; n < 40; n++) begin
      logic [VaBits-1:0] a;
      a = (VaBits'($urandom_range(0, 3)) << LineBits) |
          (VaBits'($urandom_range(0, 7)) << OffBits) |
          (VaBits'($urandom_range(0, 3)) << 3);
      do_store(a, 8'($urandom_range(1, 255)), {$urandom, $urandom}, -1);
    end
    rand_busy = 0;
    for (int k = 0; k < 4; k++) tick(ack_s, miss_s);
    check("writes_drained", 128'(exp_wr_q.size()), 128'(0));
    check("misses_drained", 128'(exp_miss_q.size()), 128'(0));
`ifdef DCST_PERF_EN
    check("perf_hit_total", 128'(perf_hit_cnt), 128'(model_hits));
    check("perf_miss_total", 128'(perf_miss_cnt), 128'(model_misses));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
